reg_bank4_wr: RTL and testbench
===============================

// Module: reg_bank4_wr
// PURPOSE
//  4-entry x WIDTH register bank consuming the one-hot write select from the
//  2-to-4 write-address decoder in the pipelined CPU register file path.
//  Captures write-back data into the selected entry and serves two registered
//  read ports, with optional same-cycle write-to-read bypass.
//  Polices the select: a non-one-hot select is blocked, flagged and counted.
// PARAMETERS
//  WIDTH   64  data width of each entry and of the read/write data ports
//  BYPASS  1   1: a read of the entry being written returns the new data; 0: returns the old data
// PORTS
//  clk        in   1      single clock; all state updates on posedge
//  reset_n    in   1      asynchronous, active-low reset
//  wr_sel     in   4      write select from decoder; one-hot or 0 (0 = no write)
//  wr_data    in   WIDTH  write data, sampled with wr_sel
//  rd_en_a    in   1      read request, port A
//  rd_addr_a  in   2      read address, port A
//  rd_en_b    in   1      read request, port B
//  rd_addr_b  in   2      read address, port B
//  rd_data_a  out  WIDTH  registered read data, port A
//  rd_vld_a   out  1      rd_data_a valid (1 cycle after rd_en_a)
//  rd_data_b  out  WIDTH  registered read data, port B
//  rd_vld_b   out  1      rd_data_b valid (1 cycle after rd_en_b)
//  written    out  4      bit i set once entry i has been written since reset
//  sel_err    out  1      sticky: a multi-hot wr_sel has been seen
//  err_cnt    out  4      count of multi-hot wr_sel cycles, saturates at 15
// BEHAVIOUR
//  - Reset (reset_n=0, async, any time, including mid-write or mid-read):
//    all entries=0, rd_data_a/b=0, rd_vld_a/b=0, written=0, sel_err=0, err_cnt=0.
//    The cycle after reset_n rises behaves as a normal first cycle.
//  - Write classification, evaluated each posedge:
//    zero: wr_sel==4'b0000 -> no state change.
//    one-hot: exactly 1 bit set -> entry[i] <= wr_data; written[i] <= 1.
//    multi-hot: 2+ bits set -> no entry is written; written unchanged;
//      sel_err <= 1; err_cnt <= err_cnt+1, held at 15 (no wrap).
//  - Reads: rd_en_x=1 at posedge -> rd_data_x <= entry[rd_addr_x] and rd_vld_x <= 1.
//    rd_en_x=0 -> rd_vld_x <= 0 and rd_data_x holds its last value.
//  - Read latency is exactly 1 cycle. Ports A and B are independent; both may
//    read the same address in the same cycle.
//  - Write/read collision (one-hot write to entry i; read of i, same posedge):
//    BYPASS=1 -> rd_data <= wr_data. BYPASS=0 -> rd_data <= pre-write entry value.
//    A multi-hot write never bypasses.
//  - No backpressure: a write is always accepted; reads are unconditional.
//  - Entry contents change only on a one-hot write or on reset.
// TESTING
//  1. Reset, then wr_sel=0001, wr_data=0xA5 -> next cycle rd_en_a, addr 0:
//     rd_data_a=0xA5, rd_vld_a=1 one cycle after rd_en_a; written=0001.
//  2. Write 0x11,0x22,0x33,0x44 to entries 0-3, then read A=3, B=1 in the same
//     cycle -> rd_data_a=0x44, rd_data_b=0x22, both valid on the same cycle.
//  3. Entry 2=0x33; write wr_sel=0100, data 0x99, read A=2 on the same cycle ->
//     rd_data_a=0x99 with BYPASS=1, 0x33 with BYPASS=0; later read returns 0x99.
//  4. wr_sel=0110, data 0xFF -> entries 1 and 2 unchanged, sel_err=1, err_cnt=1;
//     17 multi-hot cycles in total -> err_cnt=15, sel_err stays 1.
//  5. Drop reset_n mid-stream while reads are pending and a write is in progress ->
//     all outputs 0 immediately (no clock edge needed); after release, reading
//     entry 0 returns 0 and written=0000.
//  6. wr_sel=0000 with wr_data=0xDEAD for 5 cycles -> no entry changes, written
//     unchanged, sel_err unchanged.

Source files
------------

// File: rtl/reg_bank4_wr.sv
// Four-entry register bank written through a one-hot select, with two registered
// read ports, optional write-to-read bypass and policing of malformed selects.
module reg_bank4_wr #(
  parameter int WIDTH  = 64,
  parameter bit BYPASS = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [3:0]       wr_sel,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en_a,
  input  logic [1:0]       rd_addr_a,
  input  logic             rd_en_b,
  input  logic [1:0]       rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic             rd_vld_a,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             rd_vld_b,
  output logic [3:0]       written,
  output logic             sel_err,
  output logic [3:0]       err_cnt
);

  function automatic logic is_onehot(input logic [3:0] s);
    return (s != 4'd0) && ((s & (s - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] c);
    return (c == 4'hF) ? c : c + 4'd1;
  endfunction

  logic [WIDTH-1:0] mem_p0 [4];
  logic             wr_onehot_p0;
  logic             wr_multi_p0;
  logic [WIDTH-1:0] rd_next_a_p0;
  logic [WIDTH-1:0] rd_next_b_p0;

  logic [WIDTH-1:0] rd_data_a_p1;
  logic [WIDTH-1:0] rd_data_b_p1;
  logic             vld_a_p1;
  logic             vld_b_p1;
  logic [3:0]       written_p1;
  logic             sel_err_p1;
  logic [3:0]       err_cnt_p1;

  // Stage 0: classify the select and choose read sources (bypass only on a legal write)
  always_comb begin
    wr_onehot_p0 = is_onehot(wr_sel);
    wr_multi_p0  = (wr_sel != 4'd0) && !wr_onehot_p0;
    rd_next_a_p0 = mem_p0[rd_addr_a];
    rd_next_b_p0 = mem_p0[rd_addr_b];
    if (BYPASS && wr_onehot_p0 && wr_sel[rd_addr_a])
      rd_next_a_p0 = wr_data;
    if (BYPASS && wr_onehot_p0 && wr_sel[rd_addr_b])
      rd_next_b_p0 = wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++)
        mem_p0[i] <= '0;
    end else if (wr_onehot_p0) begin
      for (int i = 0; i < 4; i++)
        if (wr_sel[i])
          mem_p0[i] <= wr_data;
    end
  end

  // Stage 1: registered read ports and error/status tracking
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_a_p1 <= '0;
      rd_data_b_p1 <= '0;
      vld_a_p1     <= 1'b0;
      vld_b_p1     <= 1'b0;
    end else begin
      vld_a_p1 <= rd_en_a;
      vld_b_p1 <= rd_en_b;
      if (rd_en_a)
        rd_data_a_p1 <= rd_next_a_p0;
      if (rd_en_b)
        rd_data_b_p1 <= rd_next_b_p0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      written_p1 <= 4'd0;
      sel_err_p1 <= 1'b0;
      err_cnt_p1 <= 4'd0;
    end else begin
      if (wr_onehot_p0)
        written_p1 <= written_p1 | wr_sel;
      if (wr_multi_p0) begin
        sel_err_p1 <= 1'b1;
        err_cnt_p1 <= sat_inc(err_cnt_p1);
      end
    end
  end

  assign rd_data_a = rd_data_a_p1;
  assign rd_data_b = rd_data_b_p1;
  assign rd_vld_a  = vld_a_p1;
  assign rd_vld_b  = vld_b_p1;
  assign written   = written_p1;
  assign sel_err   = sel_err_p1;
  assign err_cnt   = err_cnt_p1;

endmodule

// File: tb/tb_reg_bank4_wr.sv
// Bench for reg_bank4_wr: directed scenarios plus randomized traffic, checked against
// an array-based model; one instance with bypass and one without share the stimulus.
module tb_reg_bank4_wr;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic [3:0]   wr_sel = '0;
  logic [W-1:0] wr_data = '0;
  logic         rd_en_a = 1'b0, rd_en_b = 1'b0;
  logic [1:0]   rd_addr_a = '0, rd_addr_b = '0;

  logic [W-1:0] rda1, rdb1, rda0, rdb0;
  logic         va1, vb1, va0, vb0;
  logic [3:0]   wr1, wr0, cnt1, cnt0;
  logic         se1, se0;

  reg_bank4_wr #(.WIDTH(W), .BYPASS(1'b1)) dut_byp (
    .clk(clk), .reset_n(reset_n), .wr_sel(wr_sel), .wr_data(wr_data),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b),
    .rd_data_a(rda1), .rd_vld_a(va1), .rd_data_b(rdb1), .rd_vld_b(vb1),
    .written(wr1), .sel_err(se1), .err_cnt(cnt1));

  reg_bank4_wr #(.WIDTH(W), .BYPASS(1'b0)) dut_nobyp (
    .clk(clk), .reset_n(reset_n), .wr_sel(wr_sel), .wr_data(wr_data),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b),
    .rd_data_a(rda0), .rd_vld_a(va0), .rd_data_b(rdb0), .rd_vld_b(vb0),
    .written(wr0), .sel_err(se0), .err_cnt(cnt0));

  always #5 clk = ~clk;

  // Reference model state
  logic [W-1:0] m_mem [4];
  logic [3:0]   m_written;
  logic         m_err;
  int           m_cnt;
  logic [W-1:0] e_a1, e_b1, e_a0, e_b0;
  logic         e_va, e_vb;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic check_all();
    chk("rd_data_a/byp",  rda1, e_a1);
    chk("rd_data_b/byp",  rdb1, e_b1);
    chk("rd_data_a/nbyp", rda0, e_a0);
    chk("rd_data_b/nbyp", rdb0, e_b0);
    chk("rd_vld_a/byp",   W'(va1), W'(e_va));
    chk("rd_vld_b/byp",   W'(vb1), W'(e_vb));
    chk("rd_vld_a/nbyp",  W'(va0), W'(e_va));
    chk("rd_vld_b/nbyp",  W'(vb0), W'(e_vb));
    chk("written/byp",    W'(wr1), W'(m_written));
    chk("written/nbyp",   W'(wr0), W'(m_written));
    chk("sel_err/byp",    W'(se1), W'(m_err));
    chk("sel_err/nbyp",   W'(se0), W'(m_err));
    chk("err_cnt/byp",    W'(cnt1), W'(m_cnt));
    chk("err_cnt/nbyp",   W'(cnt0), W'(m_cnt));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_mem[i] = '0;
    m_written = '0; m_err = 1'b0; m_cnt = 0;
    e_a1 = '0; e_b1 = '0; e_a0 = '0; e_b0 = '0; e_va = 1'b0; e_vb = 1'b0;
  endtask

  // Apply one cycle of stimulus, advance the model, then compare just after the edge.
  task automatic cyc(input logic [3:0] sel, input logic [W-1:0] d,
                     input logic ea, input logic [1:0] aa,
                     input logic eb, input logic [1:0] ab);
    int n;
    @(negedge clk);
    wr_sel = sel; wr_data = d;
    rd_en_a = ea; rd_addr_a = aa; rd_en_b = eb; rd_addr_b = ab;
    @(posedge clk);
    n = $countones(sel);
    e_va = ea; e_vb = eb;
    if (ea) begin
      e_a0 = m_mem[aa];
      e_a1 = (n == 1 && sel[aa]) ? d : m_mem[aa];
    end
    if (eb) begin
      e_b0 = m_mem[ab];
      e_b1 = (n == 1 && sel[ab]) ? d : m_mem[ab];
    end
    if (n == 1) begin
      for (int i = 0; i < 4; i++)
        if (sel[i]) begin m_mem[i] = d; m_written[i] = 1'b1; end
    end else if (n >= 2) begin
      m_err = 1'b1;
      if (m_cnt < 15) m_cnt++;
    end
    #1 check_all();
  endtask

  // Drop reset between edges with activity in flight; outputs must clear with no edge.
  task automatic async_reset();
    @(negedge clk);
    wr_sel = 4'b1000; wr_data = 64'hBAD0_BAD0; rd_en_a = 1'b1; rd_addr_a = 2'd3;
    rd_en_b = 1'b1; rd_addr_b = 2'd0;
    #2 reset_n = 1'b0;
    model_reset();
    #1 check_all();
    wr_sel = '0; rd_en_a = 1'b0; rd_en_b = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  function automatic logic [3:0] rand_sel();
    logic [3:0] s;
    int r;
    r = $urandom_range(0, 9);
    if (r < 4) s = 4'd0;
    else if (r < 8) s = 4'd1 << $urandom_range(0, 3);
    else begin
      s = 4'(1 << $urandom_range(0, 3)) | 4'(1 << $urandom_range(0, 3));
      if ($countones(s) < 2) s = 4'b1111;
    end
    return s;
  endfunction

  initial begin
    model_reset();
    #3 reset_n = 1'b0;
    #1 check_all();
    @(negedge clk);
    reset_n = 1'b1;

    // Basic write then read
    cyc(4'b0001, 64'hA5, 1'b0, 2'd0, 1'b0, 2'd0);
    cyc(4'b0000, 64'h0,  1'b1, 2'd0, 1'b0, 2'd0);
    // Fill all entries, dual read same cycle
    cyc(4'b0001, 64'h11, 1'b0, 2'd0, 1'b0, 2'd0);
    cyc(4'b0010, 64'h22, 1'b0, 2'd0, 1'b0, 2'd0);
    cyc(4'b0100, 64'h33, 1'b0, 2'd0, 1'b0, 2'd0);
    cyc(4'b1000, 64'h44, 1'b0, 2'd0, 1'b0, 2'd0);
    cyc(4'b0000, 64'h0,  1'b1, 2'd3, 1'b1, 2'd1);
    // Collision on entry 2, then plain read
    cyc(4'b0100, 64'h99, 1'b1, 2'd2, 1'b1, 2'd2);
    cyc(4'b0000, 64'h0,  1'b1, 2'd2, 1'b0, 2'd0);
    // Multi-hot: blocked, no bypass, counter saturation
    cyc(4'b0110, 64'hFF, 1'b1, 2'd1, 1'b1, 2'd2);
    for (int i = 0; i < 16; i++)
      cyc(4'b1111, 64'hFF, 1'b1, 2'(i), 1'b0, 2'd0);
    // Idle select with junk data
    for (int i = 0; i < 5; i++)
      cyc(4'b0000, 64'hDEAD, 1'b1, 2'(i), 1'b1, 2'(3 - (i % 4)));
    // Async reset mid-stream, then entry 0 reads back 0
    async_reset();
    cyc(4'b0000, 64'h0, 1'b1, 2'd0, 1'b1, 2'd3);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) async_reset();
      cyc(rand_sel(), {$urandom, $urandom}, 1'($urandom), 2'($urandom),
          1'($urandom), 2'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1);
  end

endmodule
